// File: rtl/ren_iss_dispatch.sv
// ren_iss_dispatch
//   Two-entry in-order skid buffer between rename and the issue stage.
//   Each buffered word is routed to the IQ or the LSQ by its MemRead /
//   MemWrite flags, strictly in program order: a head whose target queue is
//   full holds back everything behind it.
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   FREEZE                hold all state, no push, no accept
//   FLUSH_IN              drop all buffered words (wins over FREEZE)
//   REN_valid_IN/data_IN  instruction offered by rename
//   REN_stall_OUT         dispatch cannot accept this cycle
//   IQ_/LSQ_full_IN       target queue full flags
//   IQ_/LSQ_pushReq_OUT   push strobes (at most one per cycle)
//   IQ_/LSQ_pushData_OUT  pushed word, zero when not pushing
//   STAT_*_OUT            performance counters
//
// Configuration
//   REN_ISS_DISPATCH_STATS_EN  when defined, STAT_iq/lsq/block count IQ
//                              pushes, LSQ pushes and blocked-head cycles;
//                              otherwise the STAT ports are tied to 0.
module ren_iss_dispatch #(
    parameter int RENISS_WIDTH = 151,
    parameter int MEMREAD_BIT  = 39,
    parameter int MEMWRITE_BIT = 40
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    FREEZE,
    input  logic                    FLUSH_IN,
    input  logic                    REN_valid_IN,
    input  logic [RENISS_WIDTH-1:0] REN_data_IN,
    output logic                    REN_stall_OUT,
    input  logic                    IQ_full_IN,
    input  logic                    LSQ_full_IN,
    output logic                    IQ_pushReq_OUT,
    output logic                    LSQ_pushReq_OUT,
    output logic [RENISS_WIDTH-1:0] IQ_pushData_OUT,
    output logic [RENISS_WIDTH-1:0] LSQ_pushData_OUT,
    output logic [31:0]             STAT_iq_OUT,
    output logic [31:0]             STAT_lsq_OUT,
    output logic [31:0]             STAT_block_OUT
);

    logic [RENISS_WIDTH-1:0] buf_q [0:1];
    logic                    head;
    logic                    tail;
    logic [1:0]              count;

    logic [RENISS_WIDTH-1:0] head_word;
    logic                    head_lsq;
    logic                    head_blocked;
    logic                    accept;
    logic                    dispatch;

    assign head_word = buf_q[head];
    assign head_lsq  = head_word[MEMREAD_BIT] | head_word[MEMWRITE_BIT];

    // Head is present and live this cycle but its target queue is full.
    assign head_blocked = (count != 2'd0) && !FREEZE && !FLUSH_IN &&
                          (head_lsq ? LSQ_full_IN : IQ_full_IN);

    assign REN_stall_OUT = (count == 2'd2) || FREEZE || FLUSH_IN;
    assign accept        = REN_valid_IN && !REN_stall_OUT;
    assign dispatch      = (count != 2'd0) && !FREEZE && !FLUSH_IN && !head_blocked;

    always_comb begin
        IQ_pushReq_OUT   = 1'b0;
        LSQ_pushReq_OUT  = 1'b0;
        IQ_pushData_OUT  = '0;
        LSQ_pushData_OUT = '0;
        if (dispatch) begin
            if (head_lsq) begin
                LSQ_pushReq_OUT  = 1'b1;
                LSQ_pushData_OUT = head_word;
            end else begin
                IQ_pushReq_OUT  = 1'b1;
                IQ_pushData_OUT = head_word;
            end
        end
    end

    // Word storage carries no reset: count alone says which entries are live.
    always_ff @(posedge CLK) begin
        if (!RESET && accept)
            buf_q[tail] <= REN_data_IN;
    end

    always_ff @(posedge CLK) begin
        if (RESET || FLUSH_IN) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (!FREEZE) begin
            if (accept)
                tail <= ~tail;
            if (dispatch)
                head <= ~head;
            // accept and dispatch together leave count unchanged
            count <= count + {1'b0, accept} - {1'b0, dispatch};
        end
    end

`ifdef REN_ISS_DISPATCH_STATS_EN
    logic [31:0] stat_iq;
    logic [31:0] stat_lsq;
    logic [31:0] stat_block;

    // dispatch and head_blocked are already false under FREEZE, so the
    // counters hold without an explicit freeze term.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stat_iq    <= '0;
            stat_lsq   <= '0;
            stat_block <= '0;
        end else begin
            if (IQ_pushReq_OUT)
                stat_iq <= stat_iq + 32'd1;
            if (LSQ_pushReq_OUT)
                stat_lsq <= stat_lsq + 32'd1;
            if (head_blocked)
                stat_block <= stat_block + 32'd1;
        end
    end

    assign STAT_iq_OUT    = stat_iq;
    assign STAT_lsq_OUT   = stat_lsq;
    assign STAT_block_OUT = stat_block;
`else
    assign STAT_iq_OUT    = 32'd0;
    assign STAT_lsq_OUT   = 32'd0;
    assign STAT_block_OUT = 32'd0;
`endif

endmodule

// File: tb/tb_ren_iss_dispatch.sv
// Directed bench for ren_iss_dispatch. Inputs change 1ns after the rising
// edge; combinational outputs are sampled 1ns after that, well before the
// next edge.
module tb_ren_iss_dispatch;
    localparam int W  = 151;
    localparam int MR = 39;
    localparam int MW = 40;

    logic         CLK = 1'b0;
    logic         RESET, FREEZE, FLUSH_IN, REN_valid_IN;
    logic [W-1:0] REN_data_IN;
    logic         REN_stall_OUT;
    logic         IQ_full_IN, LSQ_full_IN;
    logic         IQ_pushReq_OUT, LSQ_pushReq_OUT;
    logic [W-1:0] IQ_pushData_OUT, LSQ_pushData_OUT;
    logic [31:0]  STAT_iq_OUT, STAT_lsq_OUT, STAT_block_OUT;

    int passed = 0;
    int total  = 0;

`ifdef REN_ISS_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    ren_iss_dispatch #(.RENISS_WIDTH(W), .MEMREAD_BIT(MR), .MEMWRITE_BIT(MW)) dut (
        .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH_IN(FLUSH_IN),
        .REN_valid_IN(REN_valid_IN), .REN_data_IN(REN_data_IN),
        .REN_stall_OUT(REN_stall_OUT),
        .IQ_full_IN(IQ_full_IN), .LSQ_full_IN(LSQ_full_IN),
        .IQ_pushReq_OUT(IQ_pushReq_OUT), .LSQ_pushReq_OUT(LSQ_pushReq_OUT),
        .IQ_pushData_OUT(IQ_pushData_OUT), .LSQ_pushData_OUT(LSQ_pushData_OUT),
        .STAT_iq_OUT(STAT_iq_OUT), .STAT_lsq_OUT(STAT_lsq_OUT),
        .STAT_block_OUT(STAT_block_OUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] mk(input int id, input bit lsq);
        logic [W-1:0] w;
        w = '0;
        w[15:0]    = 16'hA000 + id[15:0];
        w[W-1:W-8] = 8'h5A ^ id[7:0];
        w[MR]      = lsq;
        return w;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RESET = 1'b1; FREEZE = 1'b0; FLUSH_IN = 1'b0; REN_valid_IN = 1'b0;
        REN_data_IN = '0; IQ_full_IN = 1'b0; LSQ_full_IN = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        // RESET must override an offered word
        RESET = 1'b1; REN_valid_IN = 1'b1; REN_data_IN = mk(99, 0);
        tick();
        RESET = 1'b0; REN_valid_IN = 1'b0;
        #1;
        total++;
        if (IQ_pushReq_OUT !== 1'b0 || LSQ_pushReq_OUT !== 1'b0 || REN_stall_OUT !== 1'b0) begin
            $display("FAIL reset_ctrl: iq=%b lsq=%b stall=%b, want 0 0 0",
                     IQ_pushReq_OUT, LSQ_pushReq_OUT, REN_stall_OUT);
        end else passed++;
        total++;
        if (IQ_pushData_OUT !== '0 || LSQ_pushData_OUT !== '0) begin
            $display("FAIL reset_data: iq=%h lsq=%h, want 0", IQ_pushData_OUT, LSQ_pushData_OUT);
        end else passed++;
        total++;
        if (STAT_iq_OUT !== 0 || STAT_lsq_OUT !== 0 || STAT_block_OUT !== 0) begin
            $display("FAIL reset_stats: %0d %0d %0d, want 0 0 0",
                     STAT_iq_OUT, STAT_lsq_OUT, STAT_block_OUT);
        end else passed++;
    endtask

    task automatic test_single_alu;
        logic [W-1:0] a;
        a = mk(1, 0);
        do_reset();
        REN_valid_IN = 1'b1; REN_data_IN = a;
        #1;
        total++;
        if (IQ_pushReq_OUT !== 1'b0) begin
            $display("FAIL alu_no_bypass: iq=%b, want 0", IQ_pushReq_OUT);
        end else passed++;
        tick();
        REN_valid_IN = 1'b0;
        #1;
        total++;
        if (IQ_pushReq_OUT !== 1'b1 || IQ_pushData_OUT !== a || LSQ_pushReq_OUT !== 1'b0 ||
            LSQ_pushData_OUT !== '0) begin
            $display("FAIL alu_push: iq=%b data=%h lsq=%b ldata=%h, want 1 %h 0 0",
                     IQ_pushReq_OUT, IQ_pushData_OUT, LSQ_pushReq_OUT, LSQ_pushData_OUT, a);
        end else passed++;
        tick();
        total++;
        if (IQ_pushReq_OUT !== 1'b0) begin
            $display("FAIL alu_once: iq=%b, want 0", IQ_pushReq_OUT);
        end else passed++;
    endtask

    task automatic test_blocked_head;
        logic [W-1:0] ld, al;
        ld = mk(2, 1);
        al = mk(3, 0);
        do_reset();
        REN_valid_IN = 1'b1; REN_data_IN = ld;
        tick();
        // LSQ full for 5 cycles starting with the load at head
        LSQ_full_IN = 1'b1; REN_data_IN = al;
        #1;
        total++;
        if (REN_stall_OUT !== 1'b0 || LSQ_pushReq_OUT !== 1'b0 || IQ_pushReq_OUT !== 1'b0) begin
            $display("FAIL blk_first: stall=%b lsq=%b iq=%b, want 0 0 0",
                     REN_stall_OUT, LSQ_pushReq_OUT, IQ_pushReq_OUT);
        end else passed++;
        tick();
        REN_valid_IN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (REN_stall_OUT !== 1'b1 || LSQ_pushReq_OUT !== 1'b0 || IQ_pushReq_OUT !== 1'b0) begin
                $display("FAIL blk_hold%0d: stall=%b lsq=%b iq=%b, want 1 0 0",
                         i, REN_stall_OUT, LSQ_pushReq_OUT, IQ_pushReq_OUT);
            end else passed++;
            tick();
        end
        LSQ_full_IN = 1'b0;
        #1;
        total++;
        if (LSQ_pushReq_OUT !== 1'b1 || LSQ_pushData_OUT !== ld || IQ_pushReq_OUT !== 1'b0 ||
            IQ_pushData_OUT !== '0) begin
            $display("FAIL blk_lsq_push: lsq=%b data=%h iq=%b, want 1 %h 0",
                     LSQ_pushReq_OUT, LSQ_pushData_OUT, IQ_pushReq_OUT, ld);
        end else passed++;
        tick();
        total++;
        if (IQ_pushReq_OUT !== 1'b1 || IQ_pushData_OUT !== al || LSQ_pushReq_OUT !== 1'b0) begin
            $display("FAIL blk_iq_push: iq=%b data=%h lsq=%b, want 1 %h 0",
                     IQ_pushReq_OUT, IQ_pushData_OUT, LSQ_pushReq_OUT, al);
        end else passed++;
        tick();
        total++;
        if (STAT_lsq_OUT !== (STATS ? 32'd1 : 32'd0) || STAT_iq_OUT !== (STATS ? 32'd1 : 32'd0) ||
            STAT_block_OUT !== (STATS ? 32'd5 : 32'd0)) begin
            $display("FAIL blk_stats: lsq=%0d iq=%0d block=%0d, stats_en=%0d want 1 1 5 (or 0 0 0)",
                     STAT_lsq_OUT, STAT_iq_OUT, STAT_block_OUT, STATS);
        end else passed++;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] w;
        bit           el;
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                REN_valid_IN = 1'b1; REN_data_IN = mk(16 + i, i[0]);
            end else begin
                REN_valid_IN = 1'b0;
            end
            #1;
            total++;
            if (REN_stall_OUT !== 1'b0) begin
                $display("FAIL b2b_stall%0d: stall=%b, want 0", i, REN_stall_OUT);
            end else passed++;
            if (i > 0) begin
                w  = mk(16 + i - 1, (i - 1) % 2 == 1);
                el = ((i - 1) % 2 == 1);
                total++;
                if (LSQ_pushReq_OUT !== el || IQ_pushReq_OUT !== !el ||
                    (el ? LSQ_pushData_OUT : IQ_pushData_OUT) !== w) begin
                    $display("FAIL b2b_push%0d: lsq=%b iq=%b ldata=%h idata=%h, want lsq=%b data=%h",
                             i - 1, LSQ_pushReq_OUT, IQ_pushReq_OUT, LSQ_pushData_OUT,
                             IQ_pushData_OUT, el, w);
                end else passed++;
            end
            tick();
        end
    endtask

    task automatic test_flush;
        logic [W-1:0] n;
        n = mk(40, 0);
        do_reset();
        IQ_full_IN = 1'b1; REN_valid_IN = 1'b1;
        REN_data_IN = mk(30, 0); tick();
        REN_data_IN = mk(31, 0); tick();
        // target space appears in the flush cycle: flush must still win
        IQ_full_IN = 1'b0; FLUSH_IN = 1'b1; REN_data_IN = mk(32, 0);
        #1;
        total++;
        if (REN_stall_OUT !== 1'b1 || IQ_pushReq_OUT !== 1'b0 || LSQ_pushReq_OUT !== 1'b0) begin
            $display("FAIL flush_cycle: stall=%b iq=%b lsq=%b, want 1 0 0",
                     REN_stall_OUT, IQ_pushReq_OUT, LSQ_pushReq_OUT);
        end else passed++;
        tick();
        FLUSH_IN = 1'b0; REN_valid_IN = 1'b0;
        #1;
        total++;
        if (REN_stall_OUT !== 1'b0 || IQ_pushReq_OUT !== 1'b0 || LSQ_pushReq_OUT !== 1'b0) begin
            $display("FAIL flush_after: stall=%b iq=%b lsq=%b, want 0 0 0",
                     REN_stall_OUT, IQ_pushReq_OUT, LSQ_pushReq_OUT);
        end else passed++;
        REN_valid_IN = 1'b1; REN_data_IN = n;
        tick();
        REN_valid_IN = 1'b0;
        #1;
        total++;
        if (IQ_pushReq_OUT !== 1'b1 || IQ_pushData_OUT !== n) begin
            $display("FAIL flush_new: iq=%b data=%h, want 1 %h", IQ_pushReq_OUT, IQ_pushData_OUT, n);
        end else passed++;
        tick();
    endtask

    task automatic test_freeze;
        logic [W-1:0] a;
        a = mk(50, 0);
        do_reset();
        REN_valid_IN = 1'b1; REN_data_IN = a;
        tick();
        REN_valid_IN = 1'b0; FREEZE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (IQ_pushReq_OUT !== 1'b0 || REN_stall_OUT !== 1'b1 || STAT_iq_OUT !== 0) begin
                $display("FAIL frz_hold%0d: iq=%b stall=%b stat_iq=%0d, want 0 1 0",
                         i, IQ_pushReq_OUT, REN_stall_OUT, STAT_iq_OUT);
            end else passed++;
            tick();
        end
        FREEZE = 1'b0;
        #1;
        total++;
        if (IQ_pushReq_OUT !== 1'b1 || IQ_pushData_OUT !== a) begin
            $display("FAIL frz_release: iq=%b data=%h, want 1 %h", IQ_pushReq_OUT, IQ_pushData_OUT, a);
        end else passed++;
        tick();
        total++;
        if (STAT_iq_OUT !== (STATS ? 32'd1 : 32'd0)) begin
            $display("FAIL frz_stat: stat_iq=%0d, stats_en=%0d want 1 (or 0)", STAT_iq_OUT, STATS);
        end else passed++;
        // flush beats freeze
        REN_valid_IN = 1'b1; REN_data_IN = mk(51, 1);
        tick();
        REN_valid_IN = 1'b0; FREEZE = 1'b1; FLUSH_IN = 1'b1;
        tick();
        FREEZE = 1'b0; FLUSH_IN = 1'b0;
        #1;
        total++;
        if (LSQ_pushReq_OUT !== 1'b0 || IQ_pushReq_OUT !== 1'b0) begin
            $display("FAIL flush_over_freeze: lsq=%b iq=%b, want 0 0", LSQ_pushReq_OUT, IQ_pushReq_OUT);
        end else passed++;
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        IQ_full_IN = 1'b1; REN_valid_IN = 1'b1;
        REN_data_IN = mk(60, 0); tick();
        REN_data_IN = mk(61, 0); tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0; REN_valid_IN = 1'b0; IQ_full_IN = 1'b0;
        #1;
        total++;
        if (IQ_pushReq_OUT !== 1'b0 || REN_stall_OUT !== 1'b0 || IQ_pushData_OUT !== '0) begin
            $display("FAIL reset_mid: iq=%b stall=%b data=%h, want 0 0 0",
                     IQ_pushReq_OUT, REN_stall_OUT, IQ_pushData_OUT);
        end else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_blocked_head();
        test_back_to_back();
        test_flush();
        test_freeze();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1);
    end
endmodule
